synth_spi_register_port: RTL

//  Serial front end for the synth register-write bus. Replaces the parallel i_RegisterWrite* inputs of the synth top.
//  - Oversamples an SPI slave link (mode 0, MSB first) in the i_Clock domain.
//  - Assembles fixed-length frames of {address, value} and buffers them in a small FIFO.
//  - Replays them as single-cycle register writes into the existing scope/parameter/operator/voice address decode.
//  - Address and data widths, FIFO depth and an auto-increment burst mode are parameters.

---
 rtl/synth_spi_register_port.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/synth_spi_register_port.sv
// SPI mode-0 slave front end that turns {address, value} frames into single-cycle register writes.
// Six i_Clock cycles from the last SCK edge to the strobe; i_WriteStall holds frames in the FIFO, and a full FIFO drops new frames and sets the sticky o_Overflow.
module synth_spi_register_port #(
    parameter int ADDR_BITS  = 16,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BURST_EN   = 1,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_SPI_SCK,
    input  logic                 i_SPI_CS_n,
    input  logic                 i_SPI_MOSI,
    input  logic                 i_WriteStall,
    output logic                 o_RegisterWriteEnable,
    output logic [ADDR_BITS-1:0] o_RegisterWriteNumber,
    output logic [DATA_BITS-1:0] o_RegisterWriteValue,
    output logic                 o_FrameError,
    output logic                 o_Overflow,
    output logic [LVL_W-1:0]     o_FifoLevel
);

    localparam int FULL_BITS = ADDR_BITS + DATA_BITS;
    localparam int CNT_W     = $clog2(FULL_BITS + 1);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] value;
    } frame_t;

    logic [1:0] sck_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       sck_prev;
    logic       cs_prev;
    logic       sck_rise;
    logic       cs_rise;
    logic       cs_low;
    logic       mosi_bit;

    // Idle-level reset values keep a reset release from looking like an SCK or CS_n edge.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sck_sync  <= 2'b11;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sck_prev  <= 1'b1;
            cs_prev   <= 1'b1;
            sck_rise  <= 1'b0;
            cs_rise   <= 1'b0;
            cs_low    <= 1'b0;
            mosi_bit  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], i_SPI_SCK};
            cs_sync   <= {cs_sync[0], i_SPI_CS_n};
            mosi_sync <= {mosi_sync[0], i_SPI_MOSI};
            sck_prev  <= sck_sync[1];
            cs_prev   <= cs_sync[1];
            sck_rise  <= sck_sync[1] & ~sck_prev;
            cs_rise   <= cs_sync[1] & ~cs_prev;
            cs_low    <= ~cs_sync[1];
            mosi_bit  <= mosi_sync[1];
        end
    end

    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_cnt_inc;
    logic [CNT_W-1:0]     frame_len;
    logic                 burst;
    logic [FULL_BITS-1:0] shift_reg;
    logic [FULL_BITS-1:0] shift_next;
    logic [ADDR_BITS-1:0] last_addr;
    logic                 shift_en;
    logic                 frame_done;
    frame_t               push_dat;

    always_comb begin
        shift_next  = {shift_reg[FULL_BITS-2:0], mosi_bit};
        bit_cnt_inc = bit_cnt + 1'b1;
        frame_len   = CNT_W'(FULL_BITS);
        if (BURST_EN != 0 && burst) begin
            frame_len = CNT_W'(DATA_BITS);
        end
        shift_en   = sck_rise & cs_low;
        frame_done = shift_en && (bit_cnt_inc == frame_len);
        // The value is always the most recent DATA_BITS shifted in; burst frames carry no address.
        push_dat.value = shift_next[DATA_BITS-1:0];
        push_dat.addr  = shift_next[FULL_BITS-1:DATA_BITS];
        if (BURST_EN != 0 && burst) begin
            push_dat.addr = last_addr + 1'b1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            bit_cnt      <= '0;
            burst        <= 1'b0;
            shift_reg    <= '0;
            last_addr    <= '0;
            o_FrameError <= 1'b0;
        end else begin
            o_FrameError <= cs_rise && (bit_cnt != '0);
            if (cs_rise) begin
                bit_cnt <= '0;
                burst   <= 1'b0;
            end else if (shift_en) begin
                shift_reg <= shift_next;
                if (frame_done) begin
                    bit_cnt   <= '0;
                    burst     <= 1'b1;
                    last_addr <= push_dat.addr;
                end else begin
                    bit_cnt <= bit_cnt_inc;
                end
            end
        end
    end

    frame_t           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push_ok;

    always_comb begin
        fifo_full  = (o_FifoLevel == LVL_W'(FIFO_DEPTH));
        fifo_empty = (o_FifoLevel == '0);
        pop        = !fifo_empty && !i_WriteStall;
        // A pop in the same cycle frees the slot, so a full FIFO still takes the frame.
        push_ok    = frame_done && (!fifo_full || pop);
    end

    always_ff @(posedge i_Clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_FifoLevel <= '0;
            o_Overflow  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            o_FifoLevel <= o_FifoLevel + LVL_W'(push_ok) - LVL_W'(pop);
            if (frame_done && !push_ok) begin
                o_Overflow <= 1'b1;
            end
        end
    end

    logic   pop_vld;
    frame_t pop_dat;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            pop_vld               <= 1'b0;
            pop_dat               <= '0;
            o_RegisterWriteEnable <= 1'b0;
            o_RegisterWriteNumber <= '0;
            o_RegisterWriteValue  <= '0;
        end else begin
            pop_vld <= pop;
            if (pop) begin
                pop_dat <= fifo_mem[rd_ptr];
            end
            o_RegisterWriteEnable <= pop_vld;
            if (pop_vld) begin
                o_RegisterWriteNumber <= pop_dat.addr;
                o_RegisterWriteValue  <= pop_dat.value;
            end
        end
    end

endmodule
